// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Quotient pattern reported on divide-by-zero; sliced to the operand width.
  localparam logic [31:0] DIV0_QUOT_PATTERN = 32'hFFFF_FFFF;

  // Bits needed for a down-counter that starts at WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in the next dividend bit,
// subtract the divisor if it fits and report the resulting quotient bit.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] part_rem,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] new_rem,
  output logic             quot_bit
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;

  // Trial subtraction; the restored value fits WIDTH bits since it stays below the divisor.
  always_comb begin
    shifted_s = {part_rem, next_bit};
    diff_s    = shifted_s - {1'b0, divisor};
    if (shifted_s >= {1'b0, divisor}) begin
      quot_bit = 1'b1;
      new_rem  = diff_s[WIDTH-1:0];
    end else begin
      quot_bit = 1'b0;
      new_rem  = shifted_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/div_seq.sv
// Sequential signed/unsigned restoring divider with valid/ready handshakes on
// both sides; one quotient bit per cycle, sign fix-up on entry to the result.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SIGNED_EN = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             error
);

  localparam int CW = cnt_width(WIDTH);

  div_state_e       state_r, next_state_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] rem_r, quo_r, dvs_r;
  logic             neg_q_r, neg_r_r, div0_r;
  logic             in_ready_r, out_valid_r, error_r;
  logic [WIDTH-1:0] quotient_r, remainder_r;

  logic             xfer_s, signed_s, neg_a_s, neg_b_s, div0_s;
  logic [WIDTH-1:0] mag_a_s, mag_b_s;
  logic [WIDTH-1:0] step_rem_s;
  logic             step_bit_s;
  logic [WIDTH-1:0] res_quo_s, res_rem_s;

  div_step #(.WIDTH(WIDTH)) u_step (
    .part_rem (rem_r),
    .next_bit (quo_r[WIDTH-1]),
    .divisor  (dvs_r),
    .new_rem  (step_rem_s),
    .quot_bit (step_bit_s)
  );

  // Operand capture: magnitudes as unsigned WIDTH bits, so |MIN| is representable.
  always_comb begin
    xfer_s   = in_valid && in_ready_r;
    signed_s = (SIGNED_EN != 0) && signed_op;
    neg_a_s  = signed_s && dividend[WIDTH-1];
    neg_b_s  = signed_s && divisor[WIDTH-1];
    div0_s   = (divisor == '0);
    mag_a_s  = neg_a_s ? -dividend : dividend;
    mag_b_s  = neg_b_s ? -divisor : divisor;
  end

  // Result fix-up applied once, when the result registers are loaded.
  always_comb begin
    if (div0_r) begin
      res_quo_s = DIV0_QUOT_PATTERN[WIDTH-1:0];
      res_rem_s = quo_r;
    end else begin
      res_quo_s = neg_q_r ? -quo_r : quo_r;
      res_rem_s = neg_r_r ? -rem_r : rem_r;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (xfer_s) begin
          next_state_s = div0_s ? DONE : CALC;
        end else begin
          next_state_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == CW'(1)) begin
          next_state_s = DONE;
        end else begin
          next_state_s = CALC;
        end
      end
      DONE: begin
        if (out_valid_r && out_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State and handshake registers; out_valid trails entry into DONE by one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      in_ready_r  <= (next_state_s == IDLE);
      out_valid_r <= (state_r == DONE) && (next_state_s == DONE);
    end
  end

  // Working registers: operand latch, iteration and counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r   <= '0;
      rem_r   <= '0;
      quo_r   <= '0;
      dvs_r   <= '0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      div0_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (xfer_s) begin
            cnt_r   <= CW'(WIDTH);
            rem_r   <= '0;
            quo_r   <= div0_s ? dividend : mag_a_s;
            dvs_r   <= mag_b_s;
            neg_q_r <= neg_a_s ^ neg_b_s;
            neg_r_r <= neg_a_s;
            div0_r  <= div0_s;
          end
        end
        CALC: begin
          cnt_r <= cnt_r - CW'(1);
          rem_r <= step_rem_s;
          quo_r <= {quo_r[WIDTH-2:0], step_bit_s};
        end
        default: begin
        end
      endcase
    end
  end

  // Output result registers, loaded on the cycle before out_valid rises.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      quotient_r  <= '0;
      remainder_r <= '0;
      error_r     <= 1'b0;
    end else if ((state_r == DONE) && !out_valid_r) begin
      quotient_r  <= res_quo_s;
      remainder_r <= res_rem_s;
      error_r     <= div0_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign quotient  = quotient_r;
  assign remainder = remainder_r;
  assign error     = error_r;

endmodule
